// File: rtl/pet_input_conditioner.sv
// Input front end: synchronises and debounces five buttons and a touch pad, then
// derives edge pulses, touch-gesture classification and the inactivity "expecting" level.
module pet_input_conditioner #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned DEB_MS         = 20,
    parameter int unsigned TAP_MS         = 300,
    parameter int unsigned PET_MS         = 1500,
    parameter int unsigned EXP_IDLE_MS    = 8000,
    parameter int unsigned EXP_TIMEOUT_MS = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_c_raw,
    input  logic btn_u_raw,
    input  logic btn_d_raw,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    input  logic touch_raw,
    output logic pressed,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic touched,
    output logic petting,
    output logic expecting,
    output logic awaking,
    output logic go
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {T_IDLE, T_HOLD, T_PET} t_state_t;
    typedef enum logic {E_WAIT, E_ACTIVE} e_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [TW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    // Bit order: 0=c, 1=u, 2=d, 3=l, 4=r, 5=touch
    logic [5:0]  raw, sync1, sync2, stable, stable_d, rise;
    logic [15:0] deb_cnt [6];
    logic        touch_fall;

    assign raw        = {touch_raw, btn_r_raw, btn_l_raw, btn_d_raw, btn_u_raw, btn_c_raw};
    assign rise       = stable & ~stable_d;
    assign touch_fall = ~stable[5] & stable_d[5];
    assign touched    = stable[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int unsigned i = 0; i < 6; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (sat_inc(deb_cnt[i]) == 16'(DEB_MS)) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= sat_inc(deb_cnt[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {right, left, down, up, pressed} <= '0;
            awaking                          <= 1'b0;
        end else begin
            {right, left, down, up, pressed} <= rise[4:0];
            awaking                          <= |rise;
        end
    end

    t_state_t    t_state, t_state_n;
    logic [15:0] hold_cnt, hold_cnt_n;
    logic        go_n;

    // A falling touch is checked before the tick so a release always beats the pet match.
    always_comb begin
        t_state_n  = t_state;
        hold_cnt_n = hold_cnt;
        go_n       = 1'b0;
        case (t_state)
            T_IDLE: begin
                if (rise[5]) begin
                    t_state_n  = T_HOLD;
                    hold_cnt_n = '0;
                end
            end
            T_HOLD: begin
                if (touch_fall) begin
                    t_state_n = T_IDLE;
                    go_n      = (hold_cnt < 16'(TAP_MS));
                end else if (tick) begin
                    hold_cnt_n = sat_inc(hold_cnt);
                    if (hold_cnt_n == 16'(PET_MS)) t_state_n = T_PET;
                end
            end
            T_PET: begin
                if (touch_fall) t_state_n = T_IDLE;
            end
            default: t_state_n = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state  <= T_IDLE;
            hold_cnt <= '0;
            go       <= 1'b0;
            petting  <= 1'b0;
        end else begin
            t_state  <= t_state_n;
            hold_cnt <= hold_cnt_n;
            go       <= go_n;
            petting  <= (t_state_n == T_PET);
        end
    end

    e_state_t    e_state, e_state_n;
    logic [15:0] e_cnt, e_cnt_n;
    logic        btn_pulse;

    assign btn_pulse = pressed | up | down | left | right;

    always_comb begin
        e_state_n = e_state;
        e_cnt_n   = e_cnt;
        case (e_state)
            E_WAIT: begin
                if (btn_pulse || touched) begin
                    e_cnt_n = '0;
                end else if (tick) begin
                    e_cnt_n = sat_inc(e_cnt);
                    if (e_cnt_n == 16'(EXP_IDLE_MS)) begin
                        e_state_n = E_ACTIVE;
                        e_cnt_n   = '0;
                    end
                end
            end
            E_ACTIVE: begin
                if (pressed) begin
                    e_state_n = E_WAIT;
                    e_cnt_n   = '0;
                end else if (touched) begin
                    e_cnt_n = '0;
                end else if (tick) begin
                    e_cnt_n = sat_inc(e_cnt);
                    if (e_cnt_n == 16'(EXP_TIMEOUT_MS)) begin
                        e_state_n = E_WAIT;
                        e_cnt_n   = '0;
                    end
                end
            end
            default: e_state_n = E_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_state   <= E_WAIT;
            e_cnt     <= '0;
            expecting <= 1'b0;
        end else begin
            e_state   <= e_state_n;
            e_cnt     <= e_cnt_n;
            expecting <= (e_state_n == E_ACTIVE);
        end
    end

endmodule

// File: tb/tb_pet_input_conditioner.sv
// Scoreboard bench: scenarios queue expected output-vector changes with edge windows
// relative to reset release; a monitor pops and checks on every output change.
module tb_pet_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_c_raw = 1'b0, btn_u_raw = 1'b0, btn_d_raw = 1'b0;
    logic btn_l_raw = 1'b0, btn_r_raw = 1'b0, touch_raw = 1'b0;
    logic pressed, up, down, left, right, touched, petting, expecting, awaking, go;

    pet_input_conditioner #(
        .TICK_DIV(4), .DEB_MS(3), .TAP_MS(5), .PET_MS(10),
        .EXP_IDLE_MS(20), .EXP_TIMEOUT_MS(15)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_c_raw(btn_c_raw), .btn_u_raw(btn_u_raw), .btn_d_raw(btn_d_raw),
        .btn_l_raw(btn_l_raw), .btn_r_raw(btn_r_raw), .touch_raw(touch_raw),
        .pressed(pressed), .up(up), .down(down), .left(left), .right(right),
        .touched(touched), .petting(petting), .expecting(expecting),
        .awaking(awaking), .go(go)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] M_NONE = 10'b00_0000_0000;
    localparam logic [9:0] M_P    = 10'b10_0000_0000;
    localparam logic [9:0] M_L    = 10'b00_0100_0000;
    localparam logic [9:0] M_TCH  = 10'b00_0001_0000;
    localparam logic [9:0] M_PET  = 10'b00_0000_1000;
    localparam logic [9:0] M_EXP  = 10'b00_0000_0100;
    localparam logic [9:0] M_AWK  = 10'b00_0000_0010;
    localparam logic [9:0] M_GO   = 10'b00_0000_0001;

    typedef struct {
        string      name;
        logic [9:0] vec;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         R = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [9:0] outv;

    assign outv = {pressed, up, down, left, right, touched, petting, expecting, awaking, go};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        logic [9:0] prev, v;
        exp_t e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            v = outv;
            if (!mon_en || rst) begin
                prev = v;
            end else if (v !== prev) begin
                prev = v;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected: outputs %b at R+%0d, required no change", v, cyc - R);
                end else begin
                    e = q.pop_front();
                    if (v !== e.vec || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL %s: got %b at R+%0d, required %b at R+%0d..R+%0d",
                                 e.name, v, cyc - R, e.vec, e.lo - R, e.hi - R);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input string nm, input logic [9:0] v, input int rel);
        exp_t e;
        e.name = nm;
        e.vec  = v;
        e.lo   = R + rel - 1;
        e.hi   = R + rel + 1;
        q.push_back(e);
    endtask

    // Returns at the negedge just before edge R+rel, where inputs are driven.
    task automatic at_edge(input int rel);
        int a = R + rel;
        if (cyc > a - 1) begin
            n_bad++;
            $display("FAIL schedule: at R+%0d, required at most R+%0d", cyc - R, rel - 1);
        end
        while (cyc < a - 1) @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        {btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw, touch_raw} = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        R = cyc;
        mon_en = 1'b1;
        n_cmp++;
        if (outv !== M_NONE) begin
            n_bad++;
            $display("FAIL %s: outputs %b after reset, required %b", nm, outv, M_NONE);
        end
    endtask

    task automatic drain(input int rel_limit, input string nm);
        while (q.size() != 0 && cyc < R + rel_limit) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events not seen, required 0 (next %s)",
                     nm, q.size(), q[0].name);
            q.delete();
        end
    endtask

    task automatic push_touch_on(input string nm);
        expect_ev({nm, "_touch"}, M_TCH, 12);
        expect_ev({nm, "_awake"}, M_TCH | M_AWK, 13);
        expect_ev({nm, "_awake_end"}, M_TCH, 14);
    endtask

    initial begin
        // Glitch of two ticks is rejected; a held press gives one pulse
        do_reset("reset_debounce");
        expect_ev("press", M_P | M_AWK, 33);
        expect_ev("press_end", M_NONE, 34);
        at_edge(3);  btn_c_raw = 1'b1;
        at_edge(11); btn_c_raw = 1'b0;
        at_edge(20); btn_c_raw = 1'b1;
        at_edge(60); btn_c_raw = 1'b0;
        drain(66, "debounce");
        at_edge(76);

        // Tap: hold count 4 at release gives go
        do_reset("reset_tap");
        push_touch_on("tap");
        expect_ev("tap_release", M_NONE, 28);
        expect_ev("tap_go", M_GO, 29);
        expect_ev("tap_go_end", M_NONE, 30);
        at_edge(2);  touch_raw = 1'b1;
        at_edge(16); touch_raw = 1'b0;
        drain(40, "tap");
        at_edge(44);

        // Hold count exactly TAP_MS at release: no go
        do_reset("reset_long_tap");
        push_touch_on("long_tap");
        expect_ev("long_tap_release", M_NONE, 32);
        at_edge(2);  touch_raw = 1'b1;
        at_edge(20); touch_raw = 1'b0;
        drain(40, "long_tap");
        at_edge(48);

        // Pet
        do_reset("reset_pet");
        push_touch_on("pet");
        expect_ev("pet_on", M_TCH | M_PET, 52);
        expect_ev("pet_release", M_PET, 132);
        expect_ev("pet_off", M_NONE, 133);
        at_edge(2);   touch_raw = 1'b1;
        at_edge(122); touch_raw = 1'b0;
        drain(140, "pet");
        at_edge(144);

        // Expect: idle rise, timeout, press clears, left does not
        do_reset("reset_expect");
        expect_ev("exp_on", M_EXP, 80);
        expect_ev("exp_timeout", M_NONE, 140);
        expect_ev("exp_on2", M_EXP, 220);
        expect_ev("exp_press", M_P | M_AWK | M_EXP, 237);
        expect_ev("exp_press_clear", M_NONE, 238);
        expect_ev("exp_on3", M_EXP, 316);
        expect_ev("exp_left", M_L | M_AWK | M_EXP, 333);
        expect_ev("exp_left_end", M_EXP, 334);
        expect_ev("exp_timeout2", M_NONE, 376);
        at_edge(224); btn_c_raw = 1'b1;
        at_edge(240); btn_c_raw = 1'b0;
        at_edge(320); btn_l_raw = 1'b1;
        at_edge(336); btn_l_raw = 1'b0;
        drain(384, "expect");
        at_edge(390);

        // Touch holds expecting, then timeout restarts from release
        do_reset("reset_hold");
        expect_ev("hold_exp_on", M_EXP, 80);
        expect_ev("hold_touch", M_TCH | M_EXP, 96);
        expect_ev("hold_awake", M_TCH | M_EXP | M_AWK, 97);
        expect_ev("hold_awake_end", M_TCH | M_EXP, 98);
        expect_ev("hold_pet", M_TCH | M_PET | M_EXP, 136);
        expect_ev("hold_release", M_PET | M_EXP, 256);
        expect_ev("hold_pet_off", M_EXP, 257);
        expect_ev("hold_timeout", M_NONE, 316);
        at_edge(84);  touch_raw = 1'b1;
        at_edge(244); touch_raw = 1'b0;
        drain(324, "hold");
        at_edge(330);

        // Reset mid-hold aborts the gesture
        do_reset("reset_mid");
        push_touch_on("mid");
        at_edge(2);  touch_raw = 1'b1;
        at_edge(20); rst = 1'b1;
        at_edge(21); rst = 1'b0; touch_raw = 1'b0;
        R = cyc;
        n_cmp++;
        if (outv !== M_NONE) begin
            n_bad++;
            $display("FAIL mid_reset: outputs %b, required %b", outv, M_NONE);
        end
        drain(40, "mid");
        at_edge(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
